// File: rtl/midterm2_pkg.sv
// Shared register-map constants and helpers for the switch/button read-side
// user logic behind the AXI-Lite slave wrapper.
package midterm2_pkg;

  localparam logic [2:0] ADDR_STATE  = 3'd0;
  localparam logic [2:0] ADDR_EVENTS = 3'd1;
  localparam logic [2:0] ADDR_COUNT  = 3'd2;
  localparam logic [2:0] ADDR_STATUS = 3'd3;

  localparam int EVT_CNT_W = 16;

  // STATUS word: bit 1 mirrors the interrupt line, bit 0 says some input is high.
  function automatic logic [31:0] status_word(input logic irq, input logic any_high);
    return {30'h0, irq, any_high};
  endfunction

endpackage

// File: rtl/input_debouncer.sv
// One input bit: 2-FF synchronizer followed by a debouncer that adopts the new
// level only after it has disagreed with the output for DEBOUNCE_CYCLES cycles.
module input_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sw_i,
  output logic deb_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             deb_q;
  logic             deb_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // cnt_q counts disagreeing cycles already seen; the last one flips the output.
  always_comb begin
    cnt_d = cnt_q;
    deb_d = deb_q;
    if (sync2_q == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      deb_d = sync2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sw_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign deb_o = deb_q;

endmodule

// File: rtl/midterm2_input_user_logic.sv
// Read-only register block for board switches/buttons: debounced state, sticky
// read-to-clear rise events, a wrapping event counter and a level interrupt.
module midterm2_input_user_logic
  import midterm2_pkg::*;
#(
  parameter int IN_WIDTH        = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                S_AXI_ACLK,
  input  logic                S_AXI_ARESETN,
  input  logic [IN_WIDTH-1:0] SW,
  input  logic                slv_reg_rden,
  input  logic [2:0]          axi_araddr,
  output logic [31:0]         S_AXI_RDATA,
  output logic                IRQ
);

  logic [IN_WIDTH-1:0]  deb;
  logic [IN_WIDTH-1:0]  deb_dly_q;
  logic [IN_WIDTH-1:0]  rise;
  logic [IN_WIDTH-1:0]  sticky_q;
  logic [IN_WIDTH-1:0]  sticky_d;
  logic [EVT_CNT_W-1:0] evt_cnt_q;
  logic [EVT_CNT_W-1:0] evt_cnt_d;
  logic                 irq_q;
  logic [31:0]          rdata_q;
  logic [31:0]          rdata_d;
  logic [31:0]          rd_word;
  logic                 clear;

  for (genvar i = 0; i < IN_WIDTH; i++) begin : g_deb
    input_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk_i  (S_AXI_ACLK),
      .rst_ni (S_AXI_ARESETN),
      .sw_i   (SW[i]),
      .deb_o  (deb[i])
    );
  end

  assign rise  = deb & ~deb_dly_q;
  assign clear = slv_reg_rden && (axi_araddr == ADDR_EVENTS);

  // A rise landing in the clearing cycle survives the clear.
  assign sticky_d  = (clear ? '0 : sticky_q) | rise;
  assign evt_cnt_d = evt_cnt_q + {{(EVT_CNT_W-1){1'b0}}, |rise};

  // Read strobe: slv_reg_rden is a single-cycle request with axi_araddr valid in
  // the same cycle; data is registered and presented the following cycle, and
  // held unchanged until the next strobe.
  always_comb begin
    rd_word = '0;
    case (axi_araddr)
      ADDR_STATE:  rd_word = 32'(deb);
      ADDR_EVENTS: rd_word = 32'(sticky_q);
      ADDR_COUNT:  rd_word = {{(32-EVT_CNT_W){1'b0}}, evt_cnt_q};
      ADDR_STATUS: rd_word = status_word(irq_q, |deb);
      default:     rd_word = '0;
    endcase
  end

  assign rdata_d = slv_reg_rden ? rd_word : rdata_q;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      deb_dly_q <= '0;
      sticky_q  <= '0;
      evt_cnt_q <= '0;
      irq_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      deb_dly_q <= deb;
      sticky_q  <= sticky_d;
      evt_cnt_q <= evt_cnt_d;
      irq_q     <= |sticky_q;
      rdata_q   <= rdata_d;
    end
  end

  assign S_AXI_RDATA = rdata_q;
  assign IRQ         = irq_q;

endmodule

// File: tb/tb_midterm2_input_user_logic.sv
// Directed bench for the switch/button read logic: a default-parameter instance
// for debounce/event/reset behaviour and a short-debounce instance for the wrap.
module tb_midterm2_input_user_logic;
  import midterm2_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  sw;
  logic        rden;
  logic [2:0]  addr;
  logic [31:0] rdata;
  logic        irq;

  logic [3:0]  sw2;
  logic        rden2;
  logic [2:0]  addr2;
  logic [31:0] rdata2;
  logic        irq2;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;
  logic [31:0] exp_q[$];
  logic        irq_at_read;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  midterm2_input_user_logic #(
    .IN_WIDTH(8),
    .DEBOUNCE_CYCLES(16)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .SW            (sw),
    .slv_reg_rden  (rden),
    .axi_araddr    (addr),
    .S_AXI_RDATA   (rdata),
    .IRQ           (irq)
  );

  midterm2_input_user_logic #(
    .IN_WIDTH(4),
    .DEBOUNCE_CYCLES(2)
  ) dut_wrap (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .SW            (sw2),
    .slv_reg_rden  (rden2),
    .axi_araddr    (addr2),
    .S_AXI_RDATA   (rdata2),
    .IRQ           (irq2)
  );

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic second, input logic [2:0] a,
                         input logic [31:0] exp, input string tag);
    exp_q.push_back(exp);
    @(posedge clk); #1;
    if (second) begin
      rden2 = 1'b1;
      addr2 = a;
    end else begin
      rden = 1'b1;
      addr = a;
    end
    @(posedge clk); #1;
    rden  = 1'b0;
    rden2 = 1'b0;
    irq_at_read = second ? irq2 : irq;
    check(tag, second ? rdata2 : rdata, exp_q.pop_front());
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int first;
    int rises;
    int c;
    logic [3:0] nxt;

    rst_n = 1'b0; sw = '0; rden = 1'b0; addr = '0;
    sw2 = '0; rden2 = 1'b0; addr2 = '0;
    irq_at_read = 1'b0;

    repeat (3) @(posedge clk); #1;
    check("reset_rdata", rdata, 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
    rst_n = 1'b1;
    tick(2);

    // 10-cycle glitch on SW[1] is shorter than the debounce window
    sw[1] = 1'b1; tick(10); sw[1] = 1'b0; tick(40);
    do_read(1'b0, ADDR_STATE,  32'h0, "glitch_state");
    do_read(1'b0, ADDR_EVENTS, 32'h0, "glitch_events");
    do_read(1'b0, ADDR_COUNT,  32'h0, "glitch_count");

    // SW[0] rise: STATE must show it between cycle 17 and 19
    sw[0] = 1'b1; rden = 1'b1; addr = ADDR_STATE; first = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (first == 0 && rdata == 32'h1) first = n;
    end
    rden = 1'b0;
    $display("info: STATE first read 1 at cycle %0d", first);
    check("deb_latency_17_to_19", 32'(first >= 17 && first <= 19), 32'h1);
    do_read(1'b0, ADDR_STATE, 32'h1, "state_bit0");

    // bit 3 deb rise (cycle 18 after SW) coincides with the EVENTS read
    @(posedge clk); #1;
    sw[3] = 1'b1;
    repeat (18) @(posedge clk);
    #1; rden = 1'b1; addr = ADDR_EVENTS;
    @(posedge clk); #1; rden = 1'b0;
    check("collision_read", rdata, 32'h01);
    do_read(1'b0, ADDR_EVENTS, 32'h08, "collision_next");
    do_read(1'b0, ADDR_COUNT,  32'h2,  "count_two");

    // all inputs high, then asynchronous reset mid-cycle
    sw = 8'hFF; tick(25);
    do_read(1'b0, ADDR_STATE, 32'hFF, "state_all");
    check("irq_before_reset", 32'(irq), 32'h1);
    #2; rst_n = 1'b0; #1;
    check("async_rst_rdata", rdata, 32'h0);
    check("async_rst_irq", 32'(irq), 32'h0);
    tick(2); rst_n = 1'b1;
    tick(3);
    do_read(1'b0, ADDR_STATE, 32'h0, "post_rst_state");
    tick(5); rst_n = 1'b0; tick(1); rst_n = 1'b1;
    tick(12);
    do_read(1'b0, ADDR_STATE, 32'h0, "rst_discards_partial");
    tick(10);
    do_read(1'b0, ADDR_STATE, 32'hFF, "state_after_rst");
    sw = 8'h00; tick(25);
    rst_n = 1'b0; tick(1); rst_n = 1'b1; tick(2);

    // SW[2] and SW[5] rise together: one count, two sticky bits
    sw = 8'h24; tick(25);
    do_read(1'b0, ADDR_STATUS, 32'h3,  "status_irq_any");
    do_read(1'b0, ADDR_EVENTS, 32'h24, "events_24");
    check("irq_at_clear_read", 32'(irq_at_read), 32'h1);
    tick(1);
    check("irq_dropped", 32'(irq), 32'h0);
    do_read(1'b0, ADDR_COUNT,  32'h1, "count_one");
    do_read(1'b0, ADDR_EVENTS, 32'h0, "events_cleared");

    // unused indices read zero and leave sticky alone
    sw = 8'h64; tick(25);
    for (int a = 4; a <= 7; a++) do_read(1'b0, 3'(a), 32'h0, "unused_index");
    do_read(1'b0, ADDR_EVENTS, 32'h40, "events_after_unused");

    // falling edges: state only, no event or count
    sw = 8'h00; tick(25);
    do_read(1'b0, ADDR_COUNT,  32'h2, "count_after_fall");
    do_read(1'b0, ADDR_EVENTS, 32'h0, "events_after_fall");
    do_read(1'b0, ADDR_STATE,  32'h0, "state_after_fall");

    // 65537 single-bit rises, one per cycle, staggered over 4 inputs
    rises = 0; c = 0;
    while (rises < 65537 && c < 70000) begin
      for (int k = 0; k < 4; k++)
        nxt[k] = (c >= k) ? 1'(((c - k) >> 1) & 1) : 1'b0;
      @(posedge clk); #1;
      if (|(nxt & ~sw2)) rises++;
      sw2 = nxt;
      c++;
    end
    tick(20);
    do_read(1'b1, ADDR_COUNT,  32'h1, "wrap_count");
    do_read(1'b1, ADDR_EVENTS, 32'hF, "wrap_events");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/midterm2_input_user_logic.md
# midterm2_input_user_logic

AXI-Lite read-side user logic that samples board switches/buttons and presents them to the processor as read-only registers. It is the counterpart of the LED write logic: the AXI-Lite slave wrapper decodes reads and hands this block a read strobe and a word index, and this block returns the data. Each input is synchronized and debounced, and its rising edges are latched into sticky read-to-clear event bits with a wrapping event counter and a level interrupt.

## Interface
Parameters:
- IN_WIDTH, 8, number of switch/button inputs (1..32).
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required before a debounced bit changes (≥2).

Ports:
- S_AXI_ACLK  input  1  single clock for all logic.
- S_AXI_ARESETN  input  1  reset, asynchronous assert, active-low.
- SW  input  IN_WIDTH  raw asynchronous switch/button levels.
- slv_reg_rden  input  1  one-cycle read strobe from the AXI-Lite wrapper.
- axi_araddr  input  3  word index of the read (byte-address LSBs already stripped).
- S_AXI_RDATA  output  32  registered read data.
- IRQ  output  1  high while any sticky event bit is set.

## Operation
- Input path per bit: a 2-FF synchronizer feeds a debouncer. The debounced bit takes the new synchronized value only after that value has differed from the current debounced value for DEBOUNCE_CYCLES consecutive cycles. Any cycle of agreement reloads the counter.
- Rise detect: rise[i] = deb[i] & ~deb_d[i], where deb_d is deb delayed one cycle.
- Register map (word index):
  - 0, STATE: {zero-extend, deb}.
  - 1, EVENTS: {zero-extend, sticky}. Read-to-clear.
  - 2, COUNT: {16'h0, evt_cnt}.
  - 3, STATUS: {30'h0, IRQ, |deb}.
  - 4–7: 32'h0.
- Sticky update each cycle: sticky <= (clear ? 0 : sticky) | rise. clear is asserted when slv_reg_rden and axi_araddr==1.
- Read/clear collision: a rise in the same cycle as a clear leaves that bit set. The data returned for that read is the pre-clear sticky value.
- evt_cnt: 16-bit. Increments by exactly 1 in any cycle where |rise is true, even if several bits rise together. Wraps from 16'hFFFF to 0. Not cleared by reads.
- S_AXI_RDATA holds its last value when slv_reg_rden is low.
- Reset values (asynchronous, on S_AXI_ARESETN low):
  - Synchronizers, deb, deb_d, sticky, debounce counters, evt_cnt: 0.
  - S_AXI_RDATA = 32'h0, IRQ = 0.
  - Reset mid-debounce discards the partial count.

## Timing
- Read latency: S_AXI_RDATA is valid one cycle after the slv_reg_rden cycle. The wrapper samples it then.
- SW change to deb change: 2 sync cycles plus DEBOUNCE_CYCLES. With defaults, an SW edge at cycle 0 gives a deb change at cycle 18, ±1 for sampling phase.
- sticky, evt_cnt update: 1 cycle after the deb rise.
- IRQ: registered, 1 cycle after the sticky change. Falls 1 cycle after the clearing read completes, unless a new rise occurred.
- Glitch rejection: a pulse shorter than DEBOUNCE_CYCLES after synchronization never changes deb.
- Falling edges update STATE only. They generate no event and no count.

## Structure
- Shared package midterm2_pkg:
  - Word-index constants ADDR_STATE=3'd0, ADDR_EVENTS=3'd1, ADDR_COUNT=3'd2, ADDR_STATUS=3'd3.
  - EVT_CNT_W=16.
- Sub-module input_debouncer: one bit containing the synchronizer, counter, and deb output, parameterized by DEBOUNCE_CYCLES. Instantiated IN_WIDTH times in a generate loop.
- Top level contains the edge detect, sticky/count/IRQ logic, and the read mux with its output register.

## Test plan
- Reset behaviour: assert S_AXI_ARESETN low mid-run with SW=8'hFF. Required: all outputs are 0 asynchronously, with no clock edge needed. After release, reading index 0 within 10 cycles returns 32'h0.
- Debounce: SW[0] goes 0→1 and holds. Required: STATE reads 32'h1 no earlier than cycle 17 and by cycle 19. A 10-cycle pulse on SW[1] must leave STATE bit 1 at 0, EVENTS at 0, and COUNT at 0.
- Events and count: raise SW[2] and SW[5] in the same cycle and let them settle. Required: EVENTS = 32'h24, COUNT = 32'h1, IRQ = 1. Reading EVENTS again returns 32'h0, and IRQ drops 1 cycle after the clearing read.
- Clear collision: time a deb rise of bit 3 to coincide with the EVENTS read while sticky=8'h01. Required: the read returns 32'h01, and the next EVENTS read returns 32'h08.
- Counter wrap: generate 65 537 rise events (debounce forced short, DEBOUNCE_CYCLES=2). Required: COUNT reads 32'h1.
- Unused indices: read indices 4–7. Required: 32'h0 each time, and sticky is unchanged.
